// File: rtl/axi4_mem_responder.sv
// AXI4 memory slave: one write burst and one read burst in flight, each with its own FSM.
// Supports FIXED/INCR/WRAP bursts, narrow sizes, byte strobes and per-beat SLVERR/DECERR.
module axi4_mem_responder #(
  parameter int ID_WIDTH_P       = 4,
  parameter int ADDR_WIDTH_P     = 32,
  parameter int DATA_WIDTH_P     = 64,
  parameter int MEM_ADDR_WIDTH_P = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH_P-1:0]     i_awid,
  input  logic [ADDR_WIDTH_P-1:0]   i_awaddr,
  input  logic [7:0]                i_awlen,
  input  logic [2:0]                i_awsize,
  input  logic [1:0]                i_awburst,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [DATA_WIDTH_P-1:0]   i_wdata,
  input  logic [DATA_WIDTH_P/8-1:0] i_wstrb,
  input  logic                      i_wlast,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [ID_WIDTH_P-1:0]     o_bid,
  output logic [1:0]                o_bresp,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  input  logic [ID_WIDTH_P-1:0]     i_arid,
  input  logic [ADDR_WIDTH_P-1:0]   i_araddr,
  input  logic [7:0]                i_arlen,
  input  logic [2:0]                i_arsize,
  input  logic [1:0]                i_arburst,
  input  logic                      i_arvalid,
  output logic                      o_arready,
  output logic [ID_WIDTH_P-1:0]     o_rid,
  output logic [DATA_WIDTH_P-1:0]   o_rdata,
  output logic [1:0]                o_rresp,
  output logic                      o_rlast,
  output logic                      o_rvalid,
  input  logic                      i_rready
);

  localparam int STRB_W = DATA_WIDTH_P / 8;
  localparam int LSB_W  = $clog2(STRB_W);
  localparam int DEPTH  = 1 << MEM_ADDR_WIDTH_P;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_DATA} rd_state_t;

  function automatic logic [ADDR_WIDTH_P-1:0] f_next_addr(
    input logic [ADDR_WIDTH_P-1:0] addr,
    input logic [7:0]              len,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    logic [ADDR_WIDTH_P-1:0] v_b;
    logic [ADDR_WIDTH_P-1:0] v_w;
    logic [ADDR_WIDTH_P-1:0] v_inc;
    v_b   = ADDR_WIDTH_P'(1) << size;
    v_w   = (ADDR_WIDTH_P'(len) + ADDR_WIDTH_P'(1)) * v_b;
    v_inc = addr + v_b;
    case (burst)
      BURST_FIXED: return addr;
      BURST_WRAP:  return (addr & ~(v_w - ADDR_WIDTH_P'(1))) | (v_inc & (v_w - ADDR_WIDTH_P'(1)));
      default:     return v_inc;
    endcase
  endfunction

  // Decode error wins over every burst-shape error on the same beat.
  function automatic logic [1:0] f_beat_resp(
    input logic [ADDR_WIDTH_P-1:0] addr,
    input logic [7:0]              len,
    input logic [2:0]              size,
    input logic [1:0]              burst
  );
    logic v_bad;
    v_bad = (burst == 2'b11) ||
            ((32'd1 << size) > 32'(STRB_W)) ||
            ((burst == BURST_WRAP) &&
             !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    if (addr[ADDR_WIDTH_P-1:MEM_ADDR_WIDTH_P+LSB_W] != '0) return RESP_DECERR;
    else if (v_bad)                                       return RESP_SLVERR;
    else                                                  return RESP_OKAY;
  endfunction

  function automatic logic [MEM_ADDR_WIDTH_P-1:0] f_word_idx(input logic [ADDR_WIDTH_P-1:0] addr);
    return addr[MEM_ADDR_WIDTH_P+LSB_W-1:LSB_W];
  endfunction

  logic [DATA_WIDTH_P-1:0] r_mem [0:DEPTH-1];

  // ---------------- write path ----------------
  wr_state_t               r_wr_state;
  wr_state_t               w_wr_state_next;
  logic                    r_awready;
  logic                    r_wready;
  logic                    r_bvalid;
  logic [ID_WIDTH_P-1:0]   r_wr_id;
  logic [ADDR_WIDTH_P-1:0] r_wr_addr;
  logic [7:0]              r_wr_len;
  logic [2:0]              r_wr_size;
  logic [1:0]              r_wr_burst;
  logic [7:0]              r_wr_beat;
  logic [1:0]              r_wr_err;

  logic                        w_aw_fire;
  logic                        w_w_fire;
  logic                        w_b_fire;
  logic                        w_wr_last_beat;
  logic [1:0]                  w_wr_addr_resp;
  logic [1:0]                  w_wr_beat_resp;
  logic                        w_mem_we;
  logic [MEM_ADDR_WIDTH_P-1:0] w_wr_idx;

  assign w_aw_fire      = r_awready & i_awvalid;
  assign w_w_fire       = r_wready & i_wvalid;
  assign w_b_fire       = r_bvalid & i_bready;
  assign w_wr_last_beat = (r_wr_beat == r_wr_len);
  assign w_wr_addr_resp = f_beat_resp(r_wr_addr, r_wr_len, r_wr_size, r_wr_burst);
  // A wlast mismatch only flags the beat; the beat counter still decides where the burst ends.
  assign w_wr_beat_resp = ((i_wlast != w_wr_last_beat) && (w_wr_addr_resp == RESP_OKAY))
                          ? RESP_SLVERR : w_wr_addr_resp;
  assign w_mem_we       = w_w_fire && (w_wr_beat_resp == RESP_OKAY);
  assign w_wr_idx       = f_word_idx(r_wr_addr);

  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_aw_fire)                  w_wr_state_next = WR_DATA;
      WR_DATA: if (w_w_fire && w_wr_last_beat) w_wr_state_next = WR_RESP;
      WR_RESP: if (w_b_fire)                   w_wr_state_next = WR_IDLE;
      default:                                 w_wr_state_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_wr_id    <= '0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_beat  <= '0;
      r_wr_err   <= RESP_OKAY;
    end else begin
      r_wr_state <= w_wr_state_next;
      r_awready  <= (w_wr_state_next == WR_IDLE);
      r_wready   <= (w_wr_state_next == WR_DATA);
      r_bvalid   <= (w_wr_state_next == WR_RESP);
      if (w_aw_fire) begin
        r_wr_id    <= i_awid;
        r_wr_addr  <= i_awaddr;
        r_wr_len   <= i_awlen;
        r_wr_size  <= i_awsize;
        r_wr_burst <= i_awburst;
        r_wr_beat  <= '0;
        r_wr_err   <= RESP_OKAY;
      end else if (w_w_fire) begin
        r_wr_addr <= f_next_addr(r_wr_addr, r_wr_len, r_wr_size, r_wr_burst);
        r_wr_beat <= r_wr_beat + 8'd1;
        // Encodings order as OKAY < SLVERR < DECERR, so the worst case is a numeric max.
        if (w_wr_beat_resp > r_wr_err) r_wr_err <= w_wr_beat_resp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[w_wr_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bid     = r_wr_id;
  assign o_bresp   = r_wr_err;

  // ---------------- read path ----------------
  rd_state_t               r_rd_state;
  rd_state_t               w_rd_state_next;
  logic                    r_arready;
  logic                    r_rvalid;
  logic [ID_WIDTH_P-1:0]   r_rd_id;
  logic [ADDR_WIDTH_P-1:0] r_rd_addr;
  logic [7:0]              r_rd_len;
  logic [2:0]              r_rd_size;
  logic [1:0]              r_rd_burst;
  logic [7:0]              r_rd_beat;
  logic [DATA_WIDTH_P-1:0] r_rdata;
  logic [1:0]              r_rresp;
  logic                    r_rlast;

  logic                        w_ar_fire;
  logic                        w_r_fire;
  logic                        w_rd_load;
  logic [ADDR_WIDTH_P-1:0]     w_rd_next_addr;
  logic [ADDR_WIDTH_P-1:0]     w_fetch_addr;
  logic [1:0]                  w_fetch_resp;
  logic [MEM_ADDR_WIDTH_P-1:0] w_fetch_idx;

  assign w_ar_fire      = r_arready & i_arvalid;
  assign w_r_fire       = r_rvalid & i_rready;
  assign w_rd_load      = w_ar_fire || (w_r_fire && !r_rlast);
  assign w_rd_next_addr = f_next_addr(r_rd_addr, r_rd_len, r_rd_size, r_rd_burst);
  // Beat 0 comes straight from the AR channel; later beats from the latched request.
  assign w_fetch_addr   = w_ar_fire ? i_araddr : w_rd_next_addr;
  assign w_fetch_resp   = w_ar_fire ? f_beat_resp(i_araddr, i_arlen, i_arsize, i_arburst)
                                    : f_beat_resp(w_rd_next_addr, r_rd_len, r_rd_size, r_rd_burst);
  assign w_fetch_idx    = f_word_idx(w_fetch_addr);

  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_ar_fire)            w_rd_state_next = RD_DATA;
      RD_DATA: if (w_r_fire && r_rlast)  w_rd_state_next = RD_IDLE;
      default:                           w_rd_state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rd_id    <= '0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rd_beat  <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_next;
      r_arready  <= (w_rd_state_next == RD_IDLE);
      r_rvalid   <= (w_rd_state_next == RD_DATA);
      if (w_ar_fire) begin
        r_rd_id    <= i_arid;
        r_rd_addr  <= i_araddr;
        r_rd_len   <= i_arlen;
        r_rd_size  <= i_arsize;
        r_rd_burst <= i_arburst;
        r_rd_beat  <= '0;
        r_rlast    <= (i_arlen == 8'd0);
      end else if (w_r_fire && !r_rlast) begin
        r_rd_addr <= w_rd_next_addr;
        r_rd_beat <= r_rd_beat + 8'd1;
        r_rlast   <= ((r_rd_beat + 8'd1) == r_rd_len);
      end else if (w_r_fire) begin
        r_rlast <= 1'b0;
      end
      if (w_rd_load) begin
        r_rdata <= (w_fetch_resp == RESP_OKAY) ? r_mem[w_fetch_idx] : '0;
        r_rresp <= w_fetch_resp;
      end
    end
  end

  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rid     = r_rd_id;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_rlast   = r_rlast;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: expected B and R beats are queued when
// the address handshake is driven and compared when the responder delivers them.
module tb_axi4_mem_responder;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  i_awid = '0, i_arid = '0;
  logic [31:0] i_awaddr = '0, i_araddr = '0;
  logic [7:0]  i_awlen = '0, i_arlen = '0;
  logic [2:0]  i_awsize = '0, i_arsize = '0;
  logic [1:0]  i_awburst = '0, i_arburst = '0;
  logic        i_awvalid = 1'b0, i_wvalid = 1'b0, i_wlast = 1'b0, i_bready = 1'b0;
  logic        i_arvalid = 1'b0, i_rready = 1'b0;
  logic [63:0] i_wdata = '0;
  logic [7:0]  i_wstrb = '0;
  logic        o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast;
  logic [3:0]  o_bid, o_rid;
  logic [1:0]  o_bresp, o_rresp;
  logic [63:0] o_rdata;

  axi4_mem_responder dut (
    .clk(clk), .rst(rst),
    .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
    .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
    .o_wready(o_wready),
    .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
    .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
    .o_rvalid(o_rvalid), .i_rready(i_rready)
  );

  logic [81:0] all_outs;
  assign all_outs = {o_awready, o_wready, o_bvalid, o_bid, o_bresp, o_arready,
                     o_rvalid, o_rid, o_rdata, o_rresp, o_rlast};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;
  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rbeat_t rq[$];
  bexp_t  bq[$];

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] ed [16];
  logic [1:0]  er [16];
  logic [63:0] fill [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [1:0] exp_resp,
                          input int bad_beat, input bit stall);
    int t;
    bexp_t e;
    i_awid = id; i_awaddr = addr; i_awlen = len; i_awsize = size; i_awburst = burst;
    i_awvalid = 1'b1;
    t = 0;
    while (!o_awready && t < 50) begin tick(); t++; end
    check_val("aw_ready", o_awready, 1);
    if (!o_awready) begin i_awvalid = 1'b0; return; end
    e.id = id; e.resp = exp_resp;
    bq.push_back(e);
    tick();
    i_awvalid = 1'b0;
    check_val("aw2w_lat", o_wready, 1);
    for (int b = 0; b <= int'(len); b++) begin
      if (stall) begin
        i_wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      i_wvalid = 1'b1; i_wdata = wd[b]; i_wstrb = ws[b];
      i_wlast = (b == int'(len)) ^ (b == bad_beat);
      t = 0;
      while (!o_wready && t < 50) begin tick(); t++; end
      check_val("w_ready", o_wready, 1);
      if (!o_wready) begin i_wvalid = 1'b0; bq.delete(); return; end
      tick();
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    check_val("w2b_lat", o_bvalid, 1);
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        i_bready = 1'b0;
        tick();
        check_val("b_hold", {o_bvalid, o_bid, o_bresp}, {1'b1, e.id, e.resp});
      end
    end
    t = 0;
    while (!o_bvalid && t < 50) begin tick(); t++; end
    i_bready = 1'b1;
    e = bq.pop_front();
    $display("B id=%0h resp=%0d (want %0d)", o_bid, o_bresp, e.resp);
    check_val("bid", o_bid, e.id);
    check_val("bresp", o_bresp, e.resp);
    tick();
    i_bready = 1'b0;
    check_val("b2aw_lat", o_awready, 1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input bit stall);
    int t;
    int n;
    logic [63:0] d;
    rbeat_t e;
    i_arid = id; i_araddr = addr; i_arlen = len; i_arsize = size; i_arburst = burst;
    i_arvalid = 1'b1;
    t = 0;
    while (!o_arready && t < 50) begin tick(); t++; end
    check_val("ar_ready", o_arready, 1);
    if (!o_arready) begin i_arvalid = 1'b0; return; end
    for (int b = 0; b <= int'(len); b++) begin
      e.data = ed[b]; e.resp = er[b]; e.last = (b == int'(len)); e.id = id;
      rq.push_back(e);
    end
    tick();
    i_arvalid = 1'b0;
    check_val("ar2r_lat", o_rvalid, 1);
    for (int b = 0; b <= int'(len); b++) begin
      t = 0;
      while (!o_rvalid && t < 50) begin tick(); t++; end
      check_val("r_valid", o_rvalid, 1);
      if (!o_rvalid) begin rq.delete(); return; end
      if (stall) begin
        n = $urandom_range(0, 2);
        d = o_rdata;
        repeat (n) begin
          i_rready = 1'b0;
          tick();
          check_val("r_hold", {o_rvalid, o_rdata}, {1'b1, d});
        end
      end
      i_rready = 1'b1;
      e = rq.pop_front();
      $display("R id=%0h data=%h resp=%0d last=%0d (want %h)", o_rid, o_rdata, o_rresp, o_rlast, e.data);
      check_val("rdata", o_rdata, e.data);
      check_val("rresp", o_rresp, e.resp);
      check_val("rlast", o_rlast, e.last);
      check_val("rid", o_rid, e.id);
      tick();
      i_rready = 1'b0;
    end
    check_val("r2ar_lat", o_arready, 1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_val("aw_w_excl", o_awready & o_wready, 0);
      check_val("aw_b_excl", o_awready & o_bvalid, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin ws[i] = 8'hFF; er[i] = OKAY; end
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outs", all_outs, 0);
    rst = 1'b0;
    tick();
    check_val("rst_awready", o_awready, 1);
    check_val("rst_arready", o_arready, 1);

    // INCR write then readback
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    do_write(32'h40, 8'd3, 3'd3, INCR, 4'h3, OKAY, -1, 1'b0);
    for (int i = 0; i < 4; i++) ed[i] = wd[i];
    do_read(32'h40, 8'd3, 3'd3, INCR, 4'h5, 1'b0);

    // WRAP read of words 0..3 starting at word 2
    for (int i = 0; i < 4; i++) begin
      fill[i] = {56'hA0A1A2A3A4A5A6, 8'(i)};
      wd[i] = fill[i];
    end
    do_write(32'h0, 8'd3, 3'd3, INCR, 4'h1, OKAY, -1, 1'b0);
    ed[0] = fill[2]; ed[1] = fill[3]; ed[2] = fill[0]; ed[3] = fill[1];
    do_read(32'h10, 8'd3, 3'd3, WRAP, 4'h2, 1'b0);

    // FIXED narrow write with single-byte strobes
    wd[0] = 64'hFFFF_FFFF_FFFF_FF5A; ws[0] = 8'h01;
    wd[1] = 64'hFFFF_FFFF_FFFF_C3FF; ws[1] = 8'h02;
    do_write(32'h0, 8'd1, 3'd0, FIXED, 4'h6, OKAY, -1, 1'b0);
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    ed[0] = {fill[0][63:16], 16'hC35A};
    do_read(32'h0, 8'd0, 3'd3, INCR, 4'h7, 1'b0);

    // out-of-range write leaves the aliased word alone
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'h2000, 8'd0, 3'd3, INCR, 4'h8, DECERR, -1, 1'b0);
    do_read(32'h0, 8'd0, 3'd3, INCR, 4'h9, 1'b0);

    // reserved burst type
    wd[0] = 64'hDEAD_BEEF_DEAD_BEEF;
    do_write(32'h40, 8'd0, 3'd3, 2'b11, 4'hA, SLVERR, -1, 1'b0);
    ed[0] = 64'h11;
    do_read(32'h40, 8'd0, 3'd3, INCR, 4'hB, 1'b0);

    // early wlast on beat 1 of 4: SLVERR, burst still runs 4 beats
    wd[0] = 64'h01; wd[1] = 64'h02; wd[2] = 64'h03; wd[3] = 64'h04;
    do_write(32'h80, 8'd3, 3'd3, INCR, 4'hC, SLVERR, 1, 1'b0);
    ed[0] = 64'h01;
    do_read(32'h80, 8'd0, 3'd3, INCR, 4'hD, 1'b0);
    ed[0] = 64'h03; ed[1] = 64'h04;
    do_read(32'h90, 8'd1, 3'd3, INCR, 4'hE, 1'b0);

    // error reads: out of range, oversize beat, bad wrap length
    ed[0] = '0; ed[1] = '0; ed[2] = '0;
    er[0] = DECERR; er[1] = DECERR;
    do_read(32'h2000, 8'd1, 3'd3, INCR, 4'hF, 1'b0);
    er[0] = SLVERR;
    do_read(32'h40, 8'd0, 3'd4, INCR, 4'h4, 1'b0);
    er[0] = SLVERR; er[1] = SLVERR; er[2] = SLVERR;
    do_read(32'h40, 8'd2, 3'd3, WRAP, 4'h3, 1'b0);
    for (int i = 0; i < 16; i++) er[i] = OKAY;

    // random backpressure on every channel
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) wd[i] = {$urandom(), $urandom()};
      do_write(32'h200 + 32'(k) * 32'h100, 8'd7, 3'd3, INCR, 4'(k), OKAY, -1, 1'b1);
      for (int i = 0; i < 8; i++) ed[i] = wd[i];
      do_read(32'h200 + 32'(k) * 32'h100, 8'd7, 3'd3, INCR, 4'(k + 8), 1'b1);
    end

    // reset while beat 2 of a read is presented
    i_arid = 4'h5; i_araddr = 32'h40; i_arlen = 8'd3; i_arsize = 3'd3; i_arburst = INCR;
    i_arvalid = 1'b1;
    check_val("mid_arready", o_arready, 1);
    tick();
    i_arvalid = 1'b0;
    i_rready = 1'b1;
    tick();
    tick();
    i_rready = 1'b0;
    check_val("mid_beat2", o_rdata, 64'h33);
    rst = 1'b1;
    #1;
    check_val("mid_rst_outs", all_outs, 0);
    rq.delete();
    bq.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_val("post_rst_arready", o_arready, 1);
    check_val("post_rst_awready", o_awready, 1);
    for (int i = 0; i < 4; i++) ed[i] = 64'(8'h11 * (i + 1));
    do_read(32'h40, 8'd3, 3'd3, INCR, 4'h6, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

Synthesizable AXI4 slave that answers the requests generated by the AXI4 master agent. It holds a word-addressed memory and serves one write burst and one read burst at a time, independently. It supports FIXED, INCR and WRAP bursts, narrow sizes and byte strobes. Testbenches and integration tops use it as the memory endpoint, with no VIP slave agent required.

## Interface
- ID_WIDTH_P, 4, width of awid/bid/arid/rid
- ADDR_WIDTH_P, 32, byte address width
- DATA_WIDTH_P, 64, data width, power of two from 8 to 1024; strobe width STRB_W = DATA_WIDTH_P/8
- MEM_ADDR_WIDTH_P, 10, log2 of memory depth in words
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address
- awvalid in 1, awready out 1  write address handshake
- wdata/wstrb/wlast  in  DATA/STRB_W/1  write data
- wvalid in 1, wready out 1  write data handshake
- bid/bresp  out  ID/2  write response
- bvalid out 1, bready in 1  write response handshake
- arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address
- arvalid in 1, arready out 1  read address handshake
- rid/rdata/rresp/rlast  out  ID/DATA/2/1  read data
- rvalid out 1, rready in 1  read data handshake

## Operation
- **Write FSM: WR_IDLE → WR_DATA → WR_RESP → WR_IDLE.**
  - WR_IDLE: awready=1. An AW handshake latches id, addr, len, size and burst, clears the beat counter and the error accumulator, then moves to WR_DATA.
  - WR_DATA: wready=1. Each W handshake writes the wstrb-enabled bytes of wdata into word addr[MEM_ADDR_WIDTH_P+log2(STRB_W)-1 : log2(STRB_W)], then advances the address and the beat counter. The handshake at beat == len moves the FSM to WR_RESP.
  - WR_RESP: bvalid=1, bid=latched id, bresp=accumulated. A B handshake returns the FSM to WR_IDLE.
- **Read FSM: RD_IDLE → RD_DATA → RD_IDLE.**
  - RD_IDLE: arready=1. An AR handshake latches the request and loads beat 0 into the rdata register.
  - RD_DATA: rvalid=1. On each R handshake that is not the last, the next beat's word is loaded at the same edge. An R handshake with rlast=1 returns the FSM to RD_IDLE.
- **Next address** (bytes B = 1<<size):
  - FIXED: addr unchanged.
  - INCR: addr + B.
  - WRAP: boundary W = (len+1)·B; next = (addr & ~(W-1)) | ((addr+B) & (W-1)).
- **Errors:**
  - SLVERR for: burst = 2'b11; B > STRB_W; WRAP with len not in {1,3,7,15}; wlast mismatch (wlast=1 before beat len, or wlast=0 at beat len).
  - DECERR when the word index above MEM_ADDR_WIDTH_P bits is nonzero (address out of range).
  - On any erroring beat, the write is suppressed and read data is all zero.
  - bresp: worst case over the burst, with priority DECERR > SLVERR > OKAY.
  - rresp: per beat.
- A wlast mismatch does not shorten or extend the burst; the beat counter alone ends it.
- Read and write paths are fully independent. A read fetch at the same edge as a write to the same word returns the old data.
- 4 KB boundary crossing is not checked and is treated as plain INCR.
- Memory contents are not reset.

## Timing
- **Reset values:** every output is 0, including awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid and rdata. FSMs go to WR_IDLE / RD_IDLE. awready=arready=1 from the first edge after reset release.
- All outputs are registered.
- **Write latency:**
  - AW handshake at edge N → wready=1 after edge N.
  - Last W handshake at edge M → bvalid=1 after edge M.
  - B handshake → awready=1 the next cycle.
  - Minimum per burst: len+3 cycles.
- **Read latency:**
  - AR handshake at edge N → rvalid=1 with beat 0 after edge N.
  - Throughput is one beat per cycle while rready=1.
  - One idle cycle (arready=1) between bursts.
- valid is held and data is stable until the handshake completes. Stalls on wvalid=0, bready=0 or rready=0 are unlimited.
- awready and wready are never both 1; awready and bvalid are never both 1.
- **Reset mid-burst:** the burst is aborted and its pending response is dropped. Memory words already written stay written.

## Test plan
- **INCR write/read:** AW addr 0x40, len 3, size 8 B, wdata 0x11..0x44, strobes all ones, then AR with the same parameters → bresp OKAY; rdata 0x11,0x22,0x33,0x44; rlast on beat 3; rid=arid.
- **WRAP read:** after filling words 0..3, AR addr 0x10, len 3, WRAP, 8 B → data order words 2,3,0,1; rresp OKAY.
- **Strobes and FIXED:** FIXED write to 0x0, len 1, narrow size 1 B, wstrb 0x01 then 0x02 → word 0 bytes 0 and 1 updated, other bytes unchanged on readback.
- **Errors:**
  - awaddr beyond depth → bresp DECERR and memory unchanged.
  - awburst 2'b11 → SLVERR.
  - wlast asserted on beat 1 of len 3 → SLVERR after 4 beats.
  - Out-of-range read → rdata 0, rresp DECERR.
- **Backpressure and reset:**
  - Random rready/bready/wvalid gaps → data integrity holds and valid stays stable while stalled.
  - rst asserted during beat 2 of a read → all outputs 0 immediately; arready=1 after release.
